// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the single-clock FIFO.
//                - FIFO_PTR_T / FIFO_COUNT_T : width-parametrised type macros
//                - fifo_flags_t              : decoded status flags
//                - decode_flags()            : flag decode from an occupancy
//                - params_ok()               : elaboration-time margin checks
//  Revision    : 1.0  initial release
// ============================================================================

// Pointer carries one extra wrap bit above the address bits.
`define FIFO_PTR_T(AW)   logic [(AW):0]
// Occupancy must represent 0..DEPTH inclusive.
`define FIFO_COUNT_T(AW) logic [(AW):0]

package fifo_pkg;

   localparam int unsigned C_DEF_WIDTH     = 8;
   localparam int unsigned C_DEF_DEPTH     = 16;
   localparam int unsigned C_DEF_AF_MARGIN = 2;
   localparam int unsigned C_DEF_AE_MARGIN = 2;
   localparam int unsigned C_MIN_DEPTH     = 4;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   function automatic fifo_flags_t decode_flags(
      input int unsigned cnt,
      input int unsigned depth,
      input int unsigned af_margin,
      input int unsigned ae_margin
   );
      fifo_flags_t f;
      f.full         = (cnt == depth);
      f.empty        = (cnt == 0);
      f.almost_full  = (cnt >= (depth - af_margin));
      f.almost_empty = (cnt <= ae_margin);
      return f;
   endfunction

   function automatic logic params_ok(
      input int unsigned width,
      input int unsigned depth,
      input int unsigned af_margin,
      input int unsigned ae_margin
   );
      logic pow2;
      pow2 = (depth != 0) && ((depth & (depth - 1)) == 0);
      return (width >= 1) && pow2 && (depth >= C_MIN_DEPTH) &&
             (af_margin >= 1) && (af_margin <= depth - 1) &&
             (ae_margin >= 1) && (ae_margin <= depth - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : WIDTH x DEPTH register array storage for the FIFO.
//                One synchronous write port, one asynchronous read port.
//                Contents are not reset.
//  Ports       : clk            clock
//                we             write enable
//                waddr / wdata  write address / data
//                raddr / rdata  read address / combinational read data
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ctrl
//  Description : Parametrised single-clock FIFO with write ack/err pulses,
//                read err pulse, programmable almost-full/almost-empty
//                thresholds, occupancy count and synchronous flush.
//                Build option FIFO_FWFT_EN selects first-word-fall-through
//                read; otherwise dout is registered on a successful read.
//  Ports       : clk            clock (posedge)
//                clear          asynchronous active-high reset
//                flush          synchronous empty request (highest priority)
//                din / wr_en    write data / request
//                rd_en          read request (FWFT: pop)
//                dout/rd_valid  read data / valid
//                rd_err         read while empty (1-cycle pulse)
//                wr_ack/wr_err  previous write accepted / rejected pulses
//                full, empty, almost_full, almost_empty, count
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_MARGIN = 2,
   parameter int AE_MARGIN = 2
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     rd_valid,
   output logic                     rd_err,
   output logic                     wr_ack,
   output logic                     wr_err,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   typedef `FIFO_PTR_T(AW)   ptr_t;
   typedef `FIFO_COUNT_T(AW) count_t;

   generate
      if (!params_ok(WIDTH, DEPTH, AF_MARGIN, AE_MARGIN)) begin : g_bad_params
         $error("sync_fifo_ctrl: illegal WIDTH/DEPTH/AF_MARGIN/AE_MARGIN");
      end
   endgenerate

   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   count_t      count_q,  count_d;
   logic        wr_ack_q, wr_ack_d;
   logic        wr_err_q, wr_err_d;
   logic        rd_err_q, rd_err_d;
   logic        wr_ok, rd_ok;
   logic [WIDTH-1:0] mem_rdata;
   fifo_flags_t flags;

   // Flags depend only on the registered count, never on this cycle's requests.
   assign flags = decode_flags(32'(count_q), DEPTH, AF_MARGIN, AE_MARGIN);

   // The wrap bits are kept for pointer bookkeeping; occupancy is tracked
   // separately in count_q, so nothing downstream needs them.
   logic unused_wrap_bits;
   assign unused_wrap_bits = wr_ptr_q[AW] ^ rd_ptr_q[AW];

   always_comb begin
      wr_ok    = wr_en & ~flags.full  & ~flush;
      rd_ok    = rd_en & ~flags.empty & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_ack_d = wr_ok;
      wr_err_d = wr_en & flags.full  & ~flush;
      rd_err_d = rd_en & flags.empty & ~flush;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + ptr_t'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_err_q <= rd_err_d;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (din),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (mem_rdata)
   );

`ifdef FIFO_FWFT_EN
   // Head of queue is always presented; rd_en only advances rd_ptr.
   assign dout     = mem_rdata;
   assign rd_valid = ~flags.empty;
`else
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             rd_valid_q, rd_valid_d;

   always_comb begin
      dout_d     = dout_q;
      rd_valid_d = rd_ok;
      if (rd_ok) dout_d = mem_rdata;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         dout_q     <= dout_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign dout     = dout_q;
   assign rd_valid = rd_valid_q;
`endif

   assign rd_err       = rd_err_q;
   assign wr_ack       = wr_ack_q;
   assign wr_err       = wr_err_q;
   assign full         = flags.full;
   assign empty        = flags.empty;
   assign almost_full  = flags.almost_full;
   assign almost_empty = flags.almost_empty;
   assign count        = count_q;

endmodule

`default_nettype wire
